// File: rtl/tdc_timestamp_decoder.sv
// TDC timestamp decoder: turns the first non-zero thermometer sample after arming
// into a {coarse, fine} timestamp delivered over a one-entry valid/ready register.
module tdc_timestamp_decoder #(
    parameter int STAGES   = 5,
    parameter int COARSE_W = 16,
    parameter int FINE_W   = $clog2(STAGES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                arm,
    input  logic [STAGES-1:0]   thermo,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_sat,
    output logic                overflow,
    input  logic                clr_overflow,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [COARSE_W-1:0] coarse_q;

    logic                s1_vld_q;
    logic [COARSE_W-1:0] s1_coarse_q;
    logic [STAGES-1:0]   s1_thermo_q;

    logic                out_vld_q, out_vld_d;
    logic [COARSE_W-1:0] out_coarse_q, out_coarse_d;
    logic [FINE_W-1:0]   out_fine_q, out_fine_d;
    logic                out_sat_q, out_sat_d;
    logic                ovf_q, ovf_d;

    logic                hit;
    logic                launch;
    logic [FINE_W-1:0]   pop;
    logic                load;
    logic                drop;

    assign hit    = |thermo;
    assign launch = (state_q == ARMED) && hit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arm) state_d = hit ? HOLDOFF : ARMED;
            end
            ARMED: begin
                if (hit)       state_d = HOLDOFF;
                else if (!arm) state_d = IDLE;
            end
            HOLDOFF: begin
                if (!hit) state_d = arm ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bubble-tolerant fine code: plain count of ones, position ignored.
    always_comb begin
        pop = '0;
        for (int i = 0; i < STAGES; i++) begin
            pop = pop + FINE_W'(s1_thermo_q[i]);
        end
    end

    assign load = s1_vld_q && (!out_vld_q || ts_ready);
    assign drop = s1_vld_q && out_vld_q && !ts_ready;

    always_comb begin
        out_vld_d    = out_vld_q;
        out_coarse_d = out_coarse_q;
        out_fine_d   = out_fine_q;
        out_sat_d    = out_sat_q;
        ovf_d        = ovf_q;
        if (load) begin
            out_vld_d    = 1'b1;
            out_coarse_d = s1_coarse_q;
            out_fine_d   = pop;
            out_sat_d    = &s1_thermo_q;
        end else if (ts_ready) begin
            out_vld_d = 1'b0;
        end
        if (clr_overflow) ovf_d = 1'b0;
        if (drop)         ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            coarse_q     <= '0;
            s1_vld_q     <= 1'b0;
            s1_coarse_q  <= '0;
            s1_thermo_q  <= '0;
            out_vld_q    <= 1'b0;
            out_coarse_q <= '0;
            out_fine_q   <= '0;
            out_sat_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            coarse_q     <= coarse_q + 1'b1;
            s1_vld_q     <= launch;
            if (launch) begin
                s1_coarse_q <= coarse_q;
                s1_thermo_q <= thermo;
            end
            out_vld_q    <= out_vld_d;
            out_coarse_q <= out_coarse_d;
            out_fine_q   <= out_fine_d;
            out_sat_q    <= out_sat_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ts_valid  = out_vld_q;
    assign ts_coarse = out_coarse_q;
    assign ts_fine   = out_fine_q;
    assign ts_sat    = out_sat_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_timestamp_decoder.sv
// Directed bench for tdc_timestamp_decoder: hand-computed timestamps,
// overflow, holdoff, coarse wrap and mid-event reset.
module tb_tdc_timestamp_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic [4:0]  thermo;
    logic        ts_valid;
    logic        ts_ready;
    logic [15:0] ts_coarse;
    logic [2:0]  ts_fine;
    logic        ts_sat;
    logic        overflow;
    logic        clr_overflow;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [15:0] ca, cb;

    tdc_timestamp_decoder #(.STAGES(5), .COARSE_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .thermo      (thermo),
        .ts_valid    (ts_valid),
        .ts_ready    (ts_ready),
        .ts_coarse   (ts_coarse),
        .ts_fine     (ts_fine),
        .ts_sat      (ts_sat),
        .overflow    (overflow),
        .clr_overflow(clr_overflow),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled at the negedge.
    task automatic tick();
        @(posedge clock);
        if (reset) cyc = 0;
        else cyc++;
        @(negedge clock);
    endtask

    // Present one sample, then a drained sample; result is visible on return.
    task automatic fire(input logic [4:0] t, output logic [15:0] c);
        c      = cyc[15:0];
        thermo = t;
        tick();
        thermo = 5'b0;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        thermo       = 5'b0;
        ts_ready     = 1'b0;
        clr_overflow = 1'b0;
        @(negedge clock);
        tick();
        tick();
        chk("rst_valid", ts_valid, 0);
        chk("rst_coarse", ts_coarse, 0);
        chk("rst_fine", ts_fine, 0);
        chk("rst_sat", ts_sat, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);

        // 1: event at coarse 0x0010
        reset = 1'b0;
        arm   = 1'b1;
        while (cyc != 16) tick();
        chk("t1_busy", busy, 1);
        thermo = 5'b00111;
        tick();
        thermo = 5'b0;
        chk("t1_lat1", ts_valid, 0);
        tick();
        chk("t1_valid", ts_valid, 1);
        chk("t1_coarse", ts_coarse, 16'h0010);
        chk("t1_fine", ts_fine, 3);
        chk("t1_sat", ts_sat, 0);

        // 2: bubble and saturated codes, consumer ready
        ts_ready = 1'b1;
        fire(5'b01011, ca);
        chk("t2_valid", ts_valid, 1);
        chk("t2_coarse", ts_coarse, ca);
        chk("t2_fine", ts_fine, 3);
        chk("t2_sat", ts_sat, 0);
        fire(5'b11111, ca);
        chk("t2s_coarse", ts_coarse, ca);
        chk("t2s_fine", ts_fine, 5);
        chk("t2s_sat", ts_sat, 1);
        tick();
        chk("t2_drop", ts_valid, 0);

        // 3: full output register drops second event
        ts_ready = 1'b0;
        fire(5'b00001, ca);
        chk("t3_a_valid", ts_valid, 1);
        fire(5'b00011, cb);
        chk("t3_ovf", overflow, 1);
        chk("t3_hold_c", ts_coarse, ca);
        chk("t3_hold_f", ts_fine, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t3_clr", overflow, 0);
        chk("t3_still", ts_valid, 1);
        ts_ready = 1'b1;
        tick();
        chk("t3_acc", ts_valid, 0);

        // 4: arm with chain already full gives no event
        arm = 1'b0;
        tick();
        chk("t4_idle", busy, 0);
        arm    = 1'b1;
        thermo = 5'b11111;
        tick();
        tick();
        tick();
        chk("t4_noev", ts_valid, 0);
        chk("t4_hold", busy, 1);
        thermo = 5'b0;
        tick();
        ca     = cyc[15:0];
        thermo = 5'b00001;
        tick();
        thermo = 5'b0;
        arm    = 1'b0;
        tick();
        chk("t4_valid", ts_valid, 1);
        chk("t4_fine", ts_fine, 1);
        chk("t4_coarse", ts_coarse, ca);
        tick();
        chk("t4_once", ts_valid, 0);
        chk("t4_armoff", busy, 0);

        // 5: coarse wrap
        arm = 1'b1;
        while (cyc[15:0] != 16'hFFFF) tick();
        fire(5'b00111, ca);
        chk("t5_ffff", ts_coarse, 16'hFFFF);
        tick();
        fire(5'b00011, cb);
        chk("t5_wrap", ts_coarse, 16'h0002);
        chk("t5_wfine", ts_fine, 2);
        tick();

        // 6: reset one cycle after the sample
        thermo = 5'b00111;
        tick();
        thermo = 5'b0;
        reset  = 1'b1;
        tick();
        chk("t6_valid", ts_valid, 0);
        chk("t6_busy", busy, 0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_stale", ts_valid, 0);
        chk("t6_fine", ts_fine, 0);
        chk("t6_coarse", ts_coarse, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
